trolley_system_led_driver: RTL and testbench
============================================

Name: trolley_system_led_driver

Overview:
- Downstream stage of the green-LED PIO: takes its 8-bit output word and drives the physical LED pins.
- Adds global PWM brightness and per-LED blinking, configured over its own Avalon-MM slave (4 word registers).
- Sits between the PIO out_port and the top-level LEDG pins in the trolley_system Qsys build.

Parameters:
- TICK_DIV, 50000, clk cycles per blink tick (1 kHz at 50 MHz); legal range 1..65536.
- RESET_PERIOD, 500, reset value of the BLINK_PERIOD register, in ticks.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- led_in  in  8  LED word from the PIO out_port
- address  in  2  register word address
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero-extended
- led_out  out  8  registered LED pin drive

Interface decision: one clock (clk); reset_n is synchronous, active-low, sampled on posedge clk only.

Behaviour:
- Register map (write when chipselect=1, write_n=0; takes effect next cycle):
  - addr0 CTRL: bit0 EN, bit1 BLINK_EN; reset 2'b01.
  - addr1 MASK[7:0]: LEDs subject to blinking; reset 0.
  - addr2 DUTY[7:0]: brightness; reset 8'hFF.
  - addr3 PERIOD[15:0]: blink half-period in ticks; reset RESET_PERIOD.
- Reads: readdata = register at address, zero-extended to 32 bits, no wait states. Reads never have side effects.
- Prescaler:
  - Counter 0..TICK_DIV-1, increments every clk while EN=1.
  - tick=1 for one cycle when the count is TICK_DIV-1; the counter then wraps to 0.
  - EN=0 holds the counter at 0.
- Blink:
  - 16-bit blink_cnt advances on tick when EN=1 and BLINK_EN=1.
  - When blink_cnt reaches max(PERIOD,1)-1 and tick=1, blink_cnt goes to 0 and blink_phase toggles. PERIOD=0 behaves as 1.
  - A PERIOD write clears blink_cnt to 0 and sets blink_phase=1. The write wins over a coincident tick.
  - Clearing BLINK_EN or EN also clears blink_cnt and sets blink_phase=1.
  - blink_phase reset value is 1 (on).
- PWM:
  - 8-bit pwm_cnt increments every clk while EN=1, wraps 255->0; held at 0 when EN=0.
  - pwm_on = (DUTY==8'hFF) | (pwm_cnt < DUTY).
  - DUTY=0 means always off; DUTY=FF means always on (no 1/256 gap).
- Output, registered, per bit i: led_out[i] <= EN & led_in[i] & pwm_on & (~BLINK_EN | ~MASK[i] | blink_phase).
- Latency:
  - led_in to led_out: 1 clk.
  - Register write to effect on led_out: 2 clk.
- Reset values: led_out=0, readdata reflects reset register values, all counters 0, blink_phase=1.
- Reset asserted mid-operation: all state returns to reset values at the next posedge. led_out is 0 from that edge on.
- Writes to address 0..3 update only the low bits listed above. Upper writedata bits are ignored and read back as 0.

Test Plan (TICK_DIV=4, RESET_PERIOD=3):
- Reset, then led_in=8'hA5 -> led_out=0 during reset; led_out=8'hA5 one clk after release. Reads return CTRL=1, MASK=0, DUTY=FF, PERIOD=3.
- Write DUTY=8'h40, led_in=8'hFF -> led_out=8'hFF for 64 of every 256 clks, 0 for the other 192. DUTY=0 -> led_out constant 0.
- Write CTRL=3, MASK=8'h0F, led_in=8'hFF, DUTY=FF:
  - led_out bits[7:4] stay 1.
  - bits[3:0] alternate 1 and 0, changing every 12 clks (3 ticks x 4 clks).
- Mid-blink, while bits[3:0]=0, write PERIOD=2 on the same clk a tick fires -> bits[3:0] return to 1 two clks later; next toggle 8 clks after the write.
- Write CTRL=0 -> led_out=0 two clks later. Write CTRL=3 -> blinking restarts with phase on and a full first half-period.
- Write writedata=32'hFFFF_FF12 to MASK -> MASK reads back 32'h0000_0012. Assert reset_n=0 mid-blink for 1 clk -> all registers return to reset values and led_out=0.

Source files
------------

// File: rtl/trolley_system_led_driver_if.sv
// Avalon-MM slave bus for the LED driver's four configuration registers.
interface trolley_system_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/trolley_system_led_driver.sv
// LED pin driver: global PWM brightness plus per-LED blinking on top of the PIO word.
module trolley_system_led_driver #(
  parameter int TICK_DIV     = 50000,
  parameter int RESET_PERIOD = 500
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    led_in,
  trolley_system_led_driver_if.slave    bus,
  output logic [7:0]                    led_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    ctrl;
  logic [7:0]    mask;
  logic [7:0]    duty;
  logic [15:0]   period;
  logic [PW-1:0] presc;
  logic [15:0]   blink_cnt;
  logic          blink_phase;
  logic [7:0]    pwm_cnt;

  logic        en;
  logic        blink_en;
  logic        wr;
  logic        tick;
  logic        pwm_on;
  logic [15:0] period_last;
  logic [7:0]  blink_gate;

  assign en       = ctrl[0];
  assign blink_en = ctrl[1];
  assign wr       = bus.chipselect & ~bus.write_n;
  // Tick is qualified by EN so TICK_DIV=1 cannot fire while disabled.
  assign tick     = en & (presc == PRESC_LAST);
  assign pwm_on   = (duty == 8'hFF) | (pwm_cnt < duty);
  // PERIOD=0 is treated as a half-period of one tick.
  assign period_last = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign blink_gate  = ~{8{blink_en}} | ~mask | {8{blink_phase}};

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = {30'd0, ctrl};
      2'd1:    bus.readdata = {24'd0, mask};
      2'd2:    bus.readdata = {24'd0, duty};
      default: bus.readdata = {16'd0, period};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl   <= 2'b01;
      mask   <= 8'h00;
      duty   <= 8'hFF;
      period <= 16'(RESET_PERIOD);
    end else if (wr) begin
      case (bus.address)
        2'd0:    ctrl   <= bus.writedata[1:0];
        2'd1:    mask   <= bus.writedata[7:0];
        2'd2:    duty   <= bus.writedata[7:0];
        default: period <= bus.writedata[15:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      presc   <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A PERIOD write restarts the blink even if a tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n || (wr && bus.address == 2'd3) || !en || !blink_en) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == period_last) begin
        blink_cnt   <= 16'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_out <= 8'h00;
    end else begin
      led_out <= {8{en & pwm_on}} & led_in & blink_gate;
    end
  end

endmodule

// File: tb/tb_trolley_system_led_driver.sv
// Randomised self-checking bench for the LED driver against an arithmetic reference model.
module tb_trolley_system_led_driver;
  localparam int TD = 4;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] led_in;
  logic [7:0] led_out;
  int checks = 0;
  int errors = 0;

  trolley_system_led_driver_if bus ();

  trolley_system_led_driver #(.TICK_DIV(TD), .RESET_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .bus(bus), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Model: counters expressed as "enabled cycles so far" and "ticks since blink restart".
  logic [1:0]  m_ctrl;
  logic [7:0]  m_mask, m_duty, exp_led;
  logic [15:0] m_period;
  int m_run, m_ticks;

  function automatic int eff_period();
    return (m_period == 0) ? 1 : int'(m_period);
  endfunction

  function automatic bit model_phase();
    return ((m_ticks / eff_period()) % 2) == 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_ctrl};
      2'd1:    return {24'd0, m_mask};
      2'd2:    return {24'd0, m_duty};
      default: return {16'd0, m_period};
    endcase
  endfunction

  task automatic model_edge();
    bit en, blen, tick, pon, ph, wr;
    if (!reset_n) begin
      m_ctrl = 2'b01; m_mask = 8'h00; m_duty = 8'hFF; m_period = 16'(RP);
      m_run = 0; m_ticks = 0; exp_led = 8'h00;
      return;
    end
    en   = m_ctrl[0];
    blen = m_ctrl[1];
    tick = en && (m_run % TD == TD - 1);
    pon  = (m_duty == 8'hFF) || ((m_run % 256) < int'(m_duty));
    ph   = model_phase();
    exp_led = (en && pon) ? (led_in & (blen ? (~m_mask | (ph ? 8'hFF : 8'h00)) : 8'hFF)) : 8'h00;
    wr = bus.chipselect && !bus.write_n;
    if (wr && bus.address == 2'd3) m_ticks = 0;
    else if (!en || !blen)         m_ticks = 0;
    else if (tick)                 m_ticks = m_ticks + 1;
    m_run = en ? m_run + 1 : 0;
    if (wr) begin
      case (bus.address)
        2'd0:    m_ctrl   = bus.writedata[1:0];
        2'd1:    m_mask   = bus.writedata[7:0];
        2'd2:    m_duty   = bus.writedata[7:0];
        default: m_period = bus.writedata[15:0];
      endcase
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick_clk();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rst_vals [4];
    rst_vals[0] = 32'd1; rst_vals[1] = 32'd0; rst_vals[2] = 32'hFF; rst_vals[3] = 32'(RP);
    reset_n = 1'b0; led_in = 8'hA5;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
    repeat (3) begin
      tick_clk();
      checks++;
      if (led_out !== 8'h00) begin
        errors++; $display("FAIL reset_led got %h want 00", led_out);
      end
    end
    reset_n = 1'b1;
    tick_clk();
    checks++;
    if (led_out !== 8'hA5) begin
      errors++; $display("FAIL release_led got %h want a5", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== rst_vals[a]) begin
        errors++; $display("FAIL reset_read addr %0d got %h want %h", a, bus.readdata, rst_vals[a]);
      end
    end
  endtask

  task automatic test_pwm();
    int ones = 0;
    led_in = 8'hFF;
    write_reg(2'd2, 32'h40);
    tick_clk();
    repeat (256) begin
      tick_clk();
      checks++;
      if (led_out !== exp_led) begin
        errors++; $display("FAIL pwm40_cycle got %h want %h", led_out, exp_led);
      end
      if (led_out == 8'hFF) ones++;
    end
    checks++;
    if (ones != 64) begin
      errors++; $display("FAIL pwm40_on_count got %0d want 64", ones);
    end
    write_reg(2'd2, 32'h00);
    tick_clk();
    repeat (300) begin
      tick_clk();
      checks++;
      if (led_out !== 8'h00) begin
        errors++; $display("FAIL pwm0_cycle got %h want 00", led_out);
      end
    end
  endtask

  task automatic test_blink();
    led_in = 8'hFF;
    write_reg(2'd2, 32'hFF);
    write_reg(2'd1, 32'h0F);
    write_reg(2'd0, 32'h3);
    repeat (60) begin
      tick_clk();
      checks++;
      if (led_out !== exp_led || led_out[7:4] !== 4'hF) begin
        errors++; $display("FAIL blink_cycle got %h want %h", led_out, exp_led);
      end
    end
  endtask

  task automatic test_period_write();
    int guard = 0;
    while (!(!model_phase() && (m_run % TD == TD - 1)) && guard < 200) begin
      tick_clk();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++; $display("FAIL period_sync timeout got %0d cycles want <200", guard);
    end
    write_reg(2'd3, 32'd2);
    for (int k = 1; k <= 9; k++) begin
      tick_clk();
      checks++;
      if (led_out[3:0] !== ((k <= 8) ? 4'hF : 4'h0) || led_out !== exp_led) begin
        errors++; $display("FAIL period_write k=%0d got %h want %h", k, led_out, exp_led);
      end
    end
  endtask

  task automatic test_enable();
    write_reg(2'd0, 32'h0);
    tick_clk();
    checks++;
    if (led_out !== 8'h00) begin
      errors++; $display("FAIL disable got %h want 00", led_out);
    end
    write_reg(2'd0, 32'h3);
    repeat (40) begin
      tick_clk();
      checks++;
      if (led_out !== exp_led) begin
        errors++; $display("FAIL reenable got %h want %h", led_out, exp_led);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      led_in = 8'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
      bus.address = 2'($urandom);
      bus.chipselect = ($urandom_range(0, 7) != 0);
      bus.write_n = ($urandom_range(0, 9) != 0);
      case (bus.address)
        2'd0:    bus.writedata = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        2'd3:    bus.writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
        default: bus.writedata = $urandom;
      endcase
      tick_clk();
      checks++;
      if (led_out !== exp_led || bus.readdata !== exp_rd(bus.address)) begin
        errors++;
        $display("FAIL random n=%0d led got %h want %h rd got %h want %h",
                 n, led_out, exp_led, bus.readdata, exp_rd(bus.address));
      end
    end
    reset_n = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    tick_clk();
  endtask

  task automatic test_mask_upper_and_reset();
    logic [31:0] rst_vals [4];
    rst_vals[0] = 32'd1; rst_vals[1] = 32'd0; rst_vals[2] = 32'hFF; rst_vals[3] = 32'(RP);
    led_in = 8'hFF;
    write_reg(2'd1, 32'hFFFF_FF12);
    bus.address = 2'd1;
    #1;
    checks++;
    if (bus.readdata !== 32'h0000_0012) begin
      errors++; $display("FAIL mask_upper got %h want 00000012", bus.readdata);
    end
    write_reg(2'd2, 32'hFF);
    write_reg(2'd0, 32'h3);
    repeat (20) tick_clk();
    reset_n = 1'b0;
    tick_clk();
    reset_n = 1'b1;
    checks++;
    if (led_out !== 8'h00) begin
      errors++; $display("FAIL midreset_led got %h want 00", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== rst_vals[a]) begin
        errors++; $display("FAIL midreset_read addr %0d got %h want %h", a, bus.readdata, rst_vals[a]);
      end
    end
    repeat (5) begin
      tick_clk();
      checks++;
      if (led_out !== exp_led) begin
        errors++; $display("FAIL post_reset got %h want %h", led_out, exp_led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_blink();
    test_period_write();
    test_enable();
    test_random();
    test_mask_upper_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
